sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2; SRAM clocks per half-word access, legal range 1..15.
REQ-002 The block SHALL have parameter BASE_ADDR, default 1024; CPU byte address that maps to SRAM word 0.
REQ-003 The block SHALL have port clk, input, 1, the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports rd_en and wr_en, input, 1 each; memory-stage read and write requests.
REQ-006 The block SHALL have ports address and write_data, input, `WORD_WIDTH each; ALU result and Rm value.
REQ-007 The block SHALL have ports read_data, output, `WORD_WIDTH, and ready, output, 1 (low means freeze the pipeline).
REQ-008 The block SHALL have port addr_err, output, 1; out-of-range access flag.
REQ-009 The block SHALL have the following SRAM-side ports:
- sram_addr, output, 18.
- sram_dq_out, output, 16.
- sram_dq_in, input, 16.
- sram_dq_oe, output, 1.
- sram_we_n, output, 1.

Function
REQ-010 The block SHALL implement the FSM states IDLE, LOW, HIGH and DONE.
REQ-011 In IDLE, if rd_en or wr_en is high, the block SHALL latch address, write_data and the operation, and go to LOW on the next edge.
REQ-012 When rd_en and wr_en are both high, the block SHALL perform a write.
REQ-013 LOW and HIGH SHALL each last exactly WAIT_CYCLES cycles, counted by the wait counter; LOW then goes to HIGH, and HIGH then goes to DONE.
REQ-014 DONE SHALL last exactly one cycle, then go to IDLE unconditionally.
REQ-015 The block SHALL compute word = (address - BASE_ADDR) >> 2, with sram_addr = {word[16:0], 0} in LOW and {word[16:0], 1} in HIGH.
REQ-016 On a write, the block SHALL drive sram_dq_out with write_data[15:0] in LOW and write_data[31:16] in HIGH, hold sram_dq_oe high, and pulse sram_we_n low for the final cycle of each phase only.
REQ-017 On a read, sram_dq_oe and sram_we_n SHALL stay high/inactive (oe=0, we_n=1), and sram_dq_in SHALL be captured into the low half at the last LOW cycle and into the high half at the last HIGH cycle.
REQ-018 The ready output SHALL be combinational: ready = ~(rd_en | wr_en) | (state == DONE).
REQ-019 The latency from request to ready SHALL be 2*WAIT_CYCLES+2 cycles, which is 6 at the default.
REQ-020 read_data SHALL be valid from DONE and SHALL hold until the next read completes.
REQ-021 Once accepted, an access SHALL complete even if rd_en/wr_en drop mid-operation; inputs are not re-sampled until IDLE.
REQ-022 A back-to-back request SHALL be accepted in the IDLE cycle following DONE, with no extra bubble.

Reset
REQ-023 On rst low, at any time including mid-access, the block SHALL immediately enter IDLE, abandoning any partial write.
REQ-024 Reset values SHALL be:
- read_data = 0.
- addr_err = 0.
- sram_we_n = 1.
- sram_dq_oe = 0.
- sram_addr = 0.
- sram_dq_out = 0.
- wait counter = 0.
REQ-025 Release of rst SHALL take effect on the first clock edge after deassertion.

Configuration
REQ-026 With SRAM_ADDR_CHECK_EN defined, a request whose address lies outside [BASE_ADDR, BASE_ADDR + 2^19) or is not word-aligned SHALL go IDLE -> DONE directly.
- No SRAM strobe is issued.
- read_data is left unchanged.
- addr_err is high during DONE only.
REQ-027 Without SRAM_ADDR_CHECK_EN, addr_err SHALL be tied to 0, the word address SHALL be truncated to 17 bits, and every request SHALL take the full-length path.

Structure
REQ-028 `WORD_WIDTH, SRAM_ADDR_WIDTH (18), SRAM_DATA_WIDTH (16) and the FSM state encodings SHALL reside in settings.h.
REQ-029 A single sub-module, sram_wait_counter, SHALL provide a loadable down-counter with a terminal-count output; the FSM SHALL remain in sram_controller.

Verification
REQ-030 Write 0xDEADBEEF to address 1024: the bench SHALL see sram_addr 0 with dq 0xBEEF, then sram_addr 1 with dq 0xDEAD, and ready high in the 6th cycle.
REQ-031 Read address 1024 after REQ-030: read_data SHALL be 0xDEADBEEF in DONE, and sram_we_n SHALL stay high throughout.
REQ-032 Drive rst low during the HIGH phase of a write: the bench SHALL see outputs at reset values in the same cycle, and SRAM word half 1 SHALL be unwritten.
REQ-033 Issue two reads back-to-back to addresses 1028 and 1032: the second LOW phase SHALL start in the cycle after IDLE follows the first DONE, with sram_addr values 2, 3, 4, 5.
REQ-034 With SRAM_ADDR_CHECK_EN defined, read address 0x10 SHALL give ready in the 2nd cycle and addr_err = 1, with no sram_addr change and read_data unchanged.
REQ-035 With WAIT_CYCLES=1 and simultaneous rd_en and wr_en to address 1036, the bench SHALL see a write with latency 4 cycles.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// sram_controller_pkg: shared widths and FSM state encoding for the SRAM controller.
package sram_controller_pkg;
  localparam int WORD_WIDTH      = 32;
  localparam int SRAM_ADDR_WIDTH = 18;
  localparam int SRAM_DATA_WIDTH = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_e;
endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: loadable down-counter that parks at zero; tc_o flags the final cycle of a phase.
module sram_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (cnt_q == '0 ? cnt_q : cnt_q - 1'b1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/sram_controller.sv
// sram_controller: splits 32-bit CPU accesses into two 16-bit SRAM half-word phases (LOW then HIGH).
// Define SRAM_ADDR_CHECK_EN to reject out-of-range or misaligned addresses with addr_err.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_en,
  input  logic                       wr_en,
  input  logic [WORD_WIDTH-1:0]      address,
  input  logic [WORD_WIDTH-1:0]      write_data,
  output logic [WORD_WIDTH-1:0]      read_data,
  output logic                       ready,
  output logic                       addr_err,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_dq_out,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_dq_in,
  output logic                       sram_dq_oe,
  output logic                       sram_we_n
);
  localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES - 1);
  state_e                       state_q, state_d;
  logic [SRAM_ADDR_WIDTH-2:0]   word_q, word_d;
  logic [WORD_WIDTH-1:0]        wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SRAM_DATA_WIDTH-1:0]   lo_q, lo_d;
  logic                         wr_q, wr_d, load, tc, req, bad, act;
  assign req = rd_en | wr_en;
`ifdef SRAM_ADDR_CHECK_EN
  logic                  err_q;
  logic [WORD_WIDTH-1:0] off;
  assign off = address - WORD_WIDTH'(BASE_ADDR);
  assign bad = (address < WORD_WIDTH'(BASE_ADDR)) | (off >= 32'h0008_0000) | (|address[1:0]);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       err_q <= 1'b0;
    else if (state_q == IDLE && req) err_q <= bad;
  end
  assign addr_err = err_q & (state_q == DONE);
`else
  assign bad      = 1'b0;
  assign addr_err = 1'b0;
`endif
  sram_wait_counter #(.W(4)) u_wait (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (load),
    .load_val_i (RELOAD),
    .tc_o       (tc)
  );
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    word_d  = word_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: if (req) begin
        word_d  = 17'((address - WORD_WIDTH'(BASE_ADDR)) >> 2);
        wdata_d = write_data;
        wr_d    = wr_en;
        load    = ~bad;
        state_d = bad ? DONE : LOW;
      end
      LOW: if (tc) begin
        load    = 1'b1;
        state_d = HIGH;
      end
      HIGH: state_d = tc ? DONE : HIGH;
      DONE: state_d = IDLE;
    endcase
  end
  // The low half is staged so read_data only changes once the whole word is in.
  always_comb begin
    lo_d    = (state_q == LOW && tc && !wr_q) ? sram_dq_in : lo_q;
    rdata_d = (state_q == HIGH && tc && !wr_q) ? {sram_dq_in, lo_q} : rdata_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
    end
  end
  assign act         = (state_q == LOW) | (state_q == HIGH);
  assign sram_addr   = act ? {word_q, state_q == HIGH} : '0;
  assign sram_dq_oe  = act & wr_q;
  assign sram_dq_out = sram_dq_oe ? (state_q == HIGH ? wdata_q[31:16] : wdata_q[15:0]) : '0;
  assign sram_we_n   = ~(sram_dq_oe & tc);
  assign ready       = ~req | (state_q == DONE);
  assign read_data   = rdata_q;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed bench with SRAM models; dut0 uses WAIT_CYCLES=2, dut1 uses WAIT_CYCLES=1.
module tb_sram_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic        rd_v [2];
  logic        wr_v [2];
  logic [31:0] address, write_data;
  logic [31:0] rdata [2];
  logic        rdy [2], aerr [2], oe [2], we_n [2];
  logic [17:0] sa [2];
  logic [15:0] dqo [2], dqi [2];
  bit   [15:0] mem0 [0:1023];
  bit   [15:0] mem1 [0:1023];
  bit   [31:0] img [2][0:255];
  bit   [31:0] last_rd [2];
  logic [33:0] sb_q [$];
  logic [31:0] rd_q [$];
  int          checks = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYCLES(2), .BASE_ADDR(1024)) dut0 (
    .clk(clk), .rst(rst), .rd_en(rd_v[0]), .wr_en(wr_v[0]), .address(address),
    .write_data(write_data), .read_data(rdata[0]), .ready(rdy[0]), .addr_err(aerr[0]),
    .sram_addr(sa[0]), .sram_dq_out(dqo[0]), .sram_dq_in(dqi[0]), .sram_dq_oe(oe[0]),
    .sram_we_n(we_n[0]));
  sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(1024)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_v[1]), .wr_en(wr_v[1]), .address(address),
    .write_data(write_data), .read_data(rdata[1]), .ready(rdy[1]), .addr_err(aerr[1]),
    .sram_addr(sa[1]), .sram_dq_out(dqo[1]), .sram_dq_in(dqi[1]), .sram_dq_oe(oe[1]),
    .sram_we_n(we_n[1]));

  assign dqi[0] = mem0[sa[0][9:0]];
  assign dqi[1] = mem1[sa[1][9:0]];
  always @(posedge clk) begin
    if (!we_n[0]) mem0[sa[0][9:0]] <= dqo[0];
    if (!we_n[1]) mem1[sa[1][9:0]] <= dqo[1];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input int s, input logic exp_rdy);
    chk("rst_read_data", rdata[s], 0);
    chk("rst_we_n", we_n[s], 1);
    chk("rst_dq_oe", oe[s], 0);
    chk("rst_sram_addr", sa[s], 0);
    chk("rst_dq_out", dqo[s], 0);
    chk("rst_addr_err", aerr[s], 0);
    chk("rst_ready", rdy[s], exp_rdy);
  endtask

  // One access; every cycle is compared against the expected timing of a request.
  task automatic access(input int s, input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input int hold, input bit bad);
    int w, lat;
    logic [16:0] word;
    logic ph, hi;
    logic [17:0] ea;
    logic [15:0] edq;
    logic [33:0] e;
    w    = (s == 0) ? 2 : 1;
    lat  = bad ? 2 : 2 * w + 2;
    word = 17'((a - 32'd1024) >> 2);
    @(negedge clk);
    address = a; write_data = d; rd_v[s] = rd; wr_v[s] = wr;
    if (!bad && wr) begin
      sb_q.push_back({word, 1'b0, d[15:0]});
      sb_q.push_back({word, 1'b1, d[31:16]});
      img[s][word[7:0]] = d;
    end else if (!bad) last_rd[s] = img[s][word[7:0]];
    rd_q.push_back(last_rd[s]);
    for (int k = 1; k <= lat; k++) begin
      if (k == hold) begin rd_v[s] = 1'b0; wr_v[s] = 1'b0; end
      #1;
      ph  = !bad && k > 1 && k < lat;
      hi  = k >= w + 2;
      ea  = ph ? {word, hi} : 18'd0;
      edq = (ph && wr) ? (hi ? d[31:16] : d[15:0]) : 16'd0;
      chk("ready", rdy[s], (k == lat) || (k >= hold));
      chk("sram_addr", sa[s], ea);
      chk("dq_oe", oe[s], ph && wr);
      chk("dq_out", dqo[s], edq);
      chk("we_n", we_n[s], !(ph && wr && (k == w + 1 || k == 2 * w + 1)));
      chk("addr_err", aerr[s], bad && k == lat);
      if (!we_n[s]) begin
        if (sb_q.size() == 0) chk("strobe_unexpected", {sa[s], dqo[s]}, 0);
        else begin
          e = sb_q.pop_front();
          chk("strobe", {sa[s], dqo[s]}, e);
        end
      end
      if (k == lat) chk("read_data", rdata[s], rd_q.pop_front());
      if (k < lat) @(negedge clk);
    end
    chk("strobes_done", sb_q.size(), 0);
    rd_v[s] = 1'b0; wr_v[s] = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    rd_v[0] = 1'b0; rd_v[1] = 1'b0; wr_v[0] = 1'b0; wr_v[1] = 1'b0;
    address = '0; write_data = '0;
    #3;
    check_reset(0, 1'b1);
    check_reset(1, 1'b1);
    @(negedge clk); rst = 1'b1;
    access(0, 1, 0, 32'd1024, 32'hDEADBEEF, 99, 0);
    access(0, 0, 1, 32'd1024, 32'h0, 99, 0);
    access(0, 1, 0, 32'd1028, 32'h12345678, 99, 0);
    access(0, 1, 0, 32'd1032, 32'hCAFEF00D, 99, 0);
    access(0, 0, 1, 32'd1028, 32'h0, 99, 0);
    access(0, 0, 1, 32'd1032, 32'h0, 99, 0);
    access(0, 1, 0, 32'd1036, 32'h13579BDF, 3, 0);
    access(0, 0, 1, 32'd1036, 32'h0, 2, 0);
    // Reset lands in the first HIGH cycle, before the upper half is strobed.
    @(negedge clk);
    address = 32'd1040; write_data = 32'hA5A55A5A; wr_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("pre_reset_addr", sa[0], {17'd4, 1'b1});
    #1 rst = 1'b0;
    #1 check_reset(0, 1'b0);
    wr_v[0] = 1'b0;
    @(negedge clk); rst = 1'b1;
    chk("half0_written", mem0[8], 16'h5A5A);
    chk("half1_unwritten", mem0[9], 16'h0000);
    img[0][4] = 32'h00005A5A;
    last_rd[0] = '0; last_rd[1] = '0;
    access(0, 0, 1, 32'd1040, 32'h0, 99, 0);
    access(1, 1, 1, 32'd1036, 32'h0BADF00D, 99, 0);
    access(1, 0, 1, 32'd1036, 32'h0, 99, 0);
    chk("dut1_mem_lo", mem1[6], 16'hF00D);
    chk("dut1_mem_hi", mem1[7], 16'h0BAD);
`ifdef SRAM_ADDR_CHECK_EN
    access(0, 0, 1, 32'h10, 32'h0, 99, 1);
    access(0, 1, 0, 32'd1025, 32'h11111111, 99, 1);
    access(0, 0, 1, 32'd1024 + 32'h0008_0000, 32'h0, 99, 1);
    access(0, 0, 1, 32'd1024, 32'h0, 99, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
